// File: rtl/dsp_operand_feeder_if.sv
// ============================================================================
// dsp_operand_feeder_if : operand, DSP and result signal bundle for the feeder
// Rev 1.0
// ============================================================================
`default_nettype none

interface dsp_operand_feeder_if;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] in_A;
  logic [17:0] in_B;
  logic [47:0] in_C;
  logic [17:0] in_D;
  logic [17:0] dsp_A;
  logic [17:0] dsp_B;
  logic [47:0] dsp_C;
  logic [17:0] dsp_D;
  logic [47:0] dsp_P;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] out_P;
  logic        busy;

  // Feeder side
  modport slave (
    input  in_valid, in_A, in_B, in_C, in_D, dsp_P, out_ready,
    output in_ready, dsp_A, dsp_B, dsp_C, dsp_D, out_valid, out_P, busy
  );

  // Producer / DSP / consumer side
  modport master (
    output in_valid, in_A, in_B, in_C, in_D, dsp_P, out_ready,
    input  in_ready, dsp_A, dsp_B, dsp_C, dsp_D, out_valid, out_P, busy
  );
endinterface

`default_nettype wire

// File: rtl/dsp_operand_feeder.sv
// ============================================================================
// dsp_operand_feeder : buffers operand tuples, issues them credit-gated into a
// fixed-latency DSP and collects the results into a show-ahead FIFO. Rev 1.0
// ============================================================================
`default_nettype none

module dsp_operand_feeder #(
  parameter int DSP_LATENCY = 4,
  parameter int OP_DEPTH    = 4,
  parameter int RES_DEPTH   = 4
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  dsp_operand_feeder_if.slave  bus
);

  localparam int OP_AW  = $clog2(OP_DEPTH);
  localparam int RES_AW = $clog2(RES_DEPTH);
  localparam int OP_W   = 3*18 + 48;
  localparam logic [OP_AW:0]    OP_FULL  = (OP_AW+1)'(OP_DEPTH);
  localparam logic [RES_AW+1:0] CRED_LIM = (RES_AW+2)'(RES_DEPTH);

  logic [OP_W-1:0]        op_mem_q [OP_DEPTH];
  logic [OP_AW-1:0]       op_wr_q, op_wr_d, op_rd_q, op_rd_d;
  logic [OP_AW:0]         op_cnt_q, op_cnt_d;
  logic [47:0]            res_mem_q [RES_DEPTH];
  logic [RES_AW-1:0]      res_wr_q, res_wr_d, res_rd_q, res_rd_d;
  logic [RES_AW:0]        res_cnt_q, res_cnt_d;
  logic [RES_AW:0]        infl_q, infl_d;
  logic [DSP_LATENCY-1:0] vpipe_q, vpipe_d;
  logic [17:0]            dsp_a_q, dsp_a_d, dsp_b_q, dsp_b_d, dsp_d_q, dsp_d_d;
  logic [47:0]            dsp_c_q, dsp_c_d;

  logic              push, issue, capture, pop;
  logic [RES_AW+1:0] cred_used;
  logic [OP_W-1:0]   op_head;

  assign bus.in_ready  = (op_cnt_q < OP_FULL);
  assign push          = bus.in_valid & bus.in_ready;
  assign op_head       = op_mem_q[op_rd_q];
  // Credits count every result that will need a slot: in flight or still held.
  assign cred_used     = {1'b0, infl_q} + {1'b0, res_cnt_q};
  assign issue         = (op_cnt_q != '0) && (cred_used < CRED_LIM);
  assign capture       = vpipe_q[DSP_LATENCY-1];
  assign bus.out_valid = (res_cnt_q != '0);
  assign pop           = bus.out_valid & bus.out_ready;

  generate
    if (DSP_LATENCY > 1) begin : g_vpipe_multi
      assign vpipe_d = {vpipe_q[DSP_LATENCY-2:0], issue};
    end else begin : g_vpipe_single
      assign vpipe_d = issue;
    end
  endgenerate

  always_comb begin
    op_wr_d   = op_wr_q;
    op_rd_d   = op_rd_q;
    op_cnt_d  = op_cnt_q;
    res_wr_d  = res_wr_q;
    res_rd_d  = res_rd_q;
    res_cnt_d = res_cnt_q;
    infl_d    = infl_q;
    if (push)    op_wr_d  = op_wr_q + 1'b1;
    if (issue)   op_rd_d  = op_rd_q + 1'b1;
    if (capture) res_wr_d = res_wr_q + 1'b1;
    if (pop)     res_rd_d = res_rd_q + 1'b1;
    case ({push, issue})
      2'b10:   op_cnt_d = op_cnt_q + 1'b1;
      2'b01:   op_cnt_d = op_cnt_q - 1'b1;
      default: op_cnt_d = op_cnt_q;
    endcase
    case ({capture, pop})
      2'b10:   res_cnt_d = res_cnt_q + 1'b1;
      2'b01:   res_cnt_d = res_cnt_q - 1'b1;
      default: res_cnt_d = res_cnt_q;
    endcase
    case ({issue, capture})
      2'b10:   infl_d = infl_q + 1'b1;
      2'b01:   infl_d = infl_q - 1'b1;
      default: infl_d = infl_q;
    endcase
    // The DSP has no enable, so idle cycles present zero operands.
    {dsp_a_d, dsp_b_d, dsp_c_d, dsp_d_d} = '0;
    if (issue) {dsp_a_d, dsp_b_d, dsp_c_d, dsp_d_d} = op_head;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      op_wr_q   <= '0;
      op_rd_q   <= '0;
      op_cnt_q  <= '0;
      res_wr_q  <= '0;
      res_rd_q  <= '0;
      res_cnt_q <= '0;
      infl_q    <= '0;
      vpipe_q   <= '0;
      dsp_a_q   <= '0;
      dsp_b_q   <= '0;
      dsp_c_q   <= '0;
      dsp_d_q   <= '0;
    end else begin
      op_wr_q   <= op_wr_d;
      op_rd_q   <= op_rd_d;
      op_cnt_q  <= op_cnt_d;
      res_wr_q  <= res_wr_d;
      res_rd_q  <= res_rd_d;
      res_cnt_q <= res_cnt_d;
      infl_q    <= infl_d;
      vpipe_q   <= vpipe_d;
      dsp_a_q   <= dsp_a_d;
      dsp_b_q   <= dsp_b_d;
      dsp_c_q   <= dsp_c_d;
      dsp_d_q   <= dsp_d_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push)    op_mem_q[op_wr_q]   <= {bus.in_A, bus.in_B, bus.in_C, bus.in_D};
    if (capture) res_mem_q[res_wr_q] <= bus.dsp_P;
  end

  assign bus.dsp_A = dsp_a_q;
  assign bus.dsp_B = dsp_b_q;
  assign bus.dsp_C = dsp_c_q;
  assign bus.dsp_D = dsp_d_q;
  // Storage is not reset, so the head is masked while the FIFO is empty.
  assign bus.out_P = bus.out_valid ? res_mem_q[res_rd_q] : '0;
  assign bus.busy  = (op_cnt_q != '0) | (infl_q != '0) | (res_cnt_q != '0);

endmodule

`default_nettype wire

// File: tb/tb_dsp_operand_feeder.sv
// ============================================================================
// tb_dsp_operand_feeder : scoreboard bench with a pipelined ADD/SUB DSP model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dsp_operand_feeder;

  localparam int L    = 4;
  localparam int OPD  = 4;
  localparam int RESD = 4;

  logic CLK   = 1'b0;
  logic rst_n = 1'b0;
  always #5 CLK = ~CLK;

  dsp_operand_feeder_if bus ();

  dsp_operand_feeder #(
    .DSP_LATENCY (L),
    .OP_DEPTH    (OPD),
    .RES_DEPTH   (RESD)
  ) dut (
    .CLK   (CLK),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  int            last_acc_cyc = 0;
  int            issue_cnt = 0;
  logic          sub_mode = 1'b0;
  logic          rnd_done = 1'b0;
  logic [47:0]   exp_q[$];
  logic [47:0]   pop_val_q[$];
  int            pop_cyc_q[$];
  logic [47:0]   dsp_pipe [L-1];

  // ADD: P = (D+B)*A + C ; SUB: P = (D-B)*A - C, all signed, 48-bit wrap.
  function automatic logic [47:0] dsp_fn(input logic [17:0] a, input logic [17:0] b,
                                         input logic [47:0] c, input logic [17:0] d,
                                         input logic sub);
    logic signed [47:0] sa, sb, sd, sc, pre;
    sa  = {{30{a[17]}}, a};
    sb  = {{30{b[17]}}, b};
    sd  = {{30{d[17]}}, d};
    sc  = c;
    pre = sub ? (sd - sb) : (sd + sb);
    return sub ? (pre * sa - sc) : (pre * sa + sc);
  endfunction

  // DSP model: the edge that launches new operands counts as the first of L.
  always @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < L-1; i++) dsp_pipe[i] <= '0;
    end else begin
      dsp_pipe[0] <= dsp_fn(bus.dsp_A, bus.dsp_B, bus.dsp_C, bus.dsp_D, sub_mode);
      for (int i = 1; i < L-1; i++) dsp_pipe[i] <= dsp_pipe[i-1];
    end
  end
  assign bus.dsp_P = dsp_pipe[L-2];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) if (rst_n && bus.dsp_A != '0) issue_cnt <= issue_cnt + 1;

  // Expected results are queued in acceptance order; a reset discards them.
  always @(negedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
    end else if (bus.in_valid && bus.in_ready) begin
      exp_q.push_back(dsp_fn(bus.in_A, bus.in_B, bus.in_C, bus.in_D, sub_mode));
      last_acc_cyc = cyc;
    end
  end

  always @(negedge CLK) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_unexpected actual=%h required=<no result pending>", bus.out_P);
      end else begin
        logic [47:0] e;
        e = exp_q.pop_front();
        if (bus.out_P !== e) begin
          bad++;
          $display("FAIL out_P actual=%h required=%h", bus.out_P, e);
        end
      end
      pop_val_q.push_back(bus.out_P);
      pop_cyc_q.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Holds the tuple until it is accepted; returns just after the accepting edge.
  task automatic push(input logic [17:0] a, input logic [17:0] b,
                      input logic [47:0] c, input logic [17:0] d);
    int   n;
    logic acc;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_A = a; bus.in_B = b; bus.in_C = c; bus.in_D = d;
    do begin
      @(negedge CLK);
      acc = bus.in_ready;
      @(posedge CLK);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL push_timeout actual=in_ready stuck low required=accept within 200 cycles");
    end
  endtask

  task automatic push_rand();
    logic [17:0] a, b, d;
    logic [47:0] c;
    a = 18'($urandom) | 18'd1;
    b = 18'($urandom);
    d = 18'($urandom);
    c = {16'($urandom), 32'($urandom)};
    push(a, b, c, d);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < 400) begin
      tick(1);
      n++;
    end
    chk({name, "_pending"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_busy"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int n, base, np;
    bus.in_valid  = 1'b1;
    bus.in_A      = 18'd1;
    bus.in_B      = 18'd2;
    bus.in_C      = 48'd3;
    bus.in_D      = 18'd4;
    bus.out_ready = 1'b1;

    // Reset held with in_valid high
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_dsp", {bus.dsp_A, bus.dsp_B, bus.dsp_D}, 64'd0);
    chk("rst_dsp_C", 64'(bus.dsp_C), 64'd0);
    chk("rst_out_P", 64'(bus.out_P), 64'd0);
    @(posedge CLK);
    #1;
    rst_n = 1'b1;
    @(negedge CLK);
    #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge CLK);
    #1;
    bus.in_valid = 1'b0;
    drain("rst_tuple");
    chk("rst_tuple_val", 64'(pop_val_q[$]), 64'h9);

    // ADD single with latency check
    push(18'hA, 18'hB, 48'hC, 18'hD);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("add_single_latency", 64'(cyc - (last_acc_cyc + 1)), 64'(L + 1));
    drain("add_single");
    chk("add_single_val", 64'(pop_val_q[$]), 64'h0000000000FC);

    // ADD back-to-back burst
    push(18'hA, 18'hB, 48'hC, 18'hD);
    push(18'hA7, 18'hB6, 48'hC7, 18'hD6);
    bus.in_valid = 1'b0;
    drain("add_burst");
    chk("add_burst_first", 64'(pop_val_q[$-1]), 64'hFC);
    chk("add_burst_second", 64'(pop_val_q[$]), 64'h1031B);
    chk("add_burst_consecutive", 64'(pop_cyc_q[$] - pop_cyc_q[$-1]), 64'd1);

    // SUB giving a negative result
    sub_mode = 1'b1;
    push(18'hA, 18'h1, 48'h1111, 18'hDD);
    bus.in_valid = 1'b0;
    drain("sub_neg");
    chk("sub_neg_val", 64'(pop_val_q[$]), 64'hFFFFFFFFF787);
    sub_mode = 1'b0;

    // Backpressure: credits cap issue, operand FIFO fills
    bus.out_ready = 1'b0;
    base = issue_cnt;
    np   = pop_val_q.size();
    for (int i = 0; i < 8; i++) push_rand();
    bus.in_valid = 1'b0;
    tick(8);
    chk("bp_issues", 64'(issue_cnt - base), 64'(RESD));
    chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_busy", 64'(bus.busy), 64'd1);
    chk("bp_pending", 64'(exp_q.size()), 64'd8);
    bus.out_ready = 1'b1;
    drain("bp");
    chk("bp_result_count", 64'(pop_val_q.size() - np), 64'd8);

    // Reset with two results in flight
    push_rand();
    push_rand();
    bus.in_valid = 1'b0;
    tick(1);
    #2;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    np = pop_val_q.size();
    tick(12);
    chk("midrst_no_output", 64'(pop_val_q.size() - np), 64'd0);
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    push(18'd3, 18'd5, 48'd7, 18'd2);
    bus.in_valid = 1'b0;
    drain("midrst_new");
    chk("midrst_new_count", 64'(pop_val_q.size() - np), 64'd1);
    chk("midrst_new_val", 64'(pop_val_q[$]), 64'h1C);

    // Randomized traffic with random consumer stalls, both DSP variants
    for (int m = 0; m < 2; m++) begin
      sub_mode = m[0];
      rnd_done = 1'b0;
      np = pop_val_q.size();
      fork
        begin
          for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 2) == 0) begin
              bus.in_valid = 1'b0;
              tick(1);
            end
            push_rand();
          end
          bus.in_valid = 1'b0;
          rnd_done = 1'b1;
        end
        begin
          while (!rnd_done) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            tick(1);
          end
        end
      join
      bus.out_ready = 1'b1;
      drain("rand");
      chk("rand_result_count", 64'(pop_val_q.size() - np), 64'd20);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
